// File: rtl/biriscv_fetch_queue_pkg.sv
// Shared core definitions for the fetch queue: payload layout and the
// decode-flag bit positions also used by the decode stage.
package biriscv_fetch_queue_pkg;

  // Payload layout: {instr[31:0], pc[31:0], fault_fetch, fault_page, flags[7:0]}
  localparam int PAYLOAD_W       = 74;
  localparam int FLAGS_LSB       = 0;
  localparam int FAULT_PAGE_BIT  = 8;
  localparam int FAULT_FETCH_BIT = 9;
  localparam int PC_LSB          = 10;
  localparam int INSTR_LSB       = 42;

  // Decode flag bit positions within the 8-bit flag field
  localparam int FLAG_EXEC     = 0;
  localparam int FLAG_LSU      = 1;
  localparam int FLAG_BRANCH   = 2;
  localparam int FLAG_MUL      = 3;
  localparam int FLAG_DIV      = 4;
  localparam int FLAG_CSR      = 5;
  localparam int FLAG_RD_VALID = 6;
  localparam int FLAG_INVALID  = 7;

  typedef logic [PAYLOAD_W-1:0] payload_t;

  // Assemble one queue entry from the decoded instruction fields.
  function automatic payload_t pack_payload(input logic [31:0] instr,
                                            input logic [31:0] pc,
                                            input logic        fault_fetch,
                                            input logic        fault_page,
                                            input logic [7:0]  flags);
    return {instr, pc, fault_fetch, fault_page, flags};
  endfunction

endpackage

// File: rtl/biriscv_fetch_queue_ram.sv
// DEPTH x 74 register array with two write ports and two combinational
// read ports. Contents clear on reset so idle payload outputs read as zero.
module biriscv_fetch_queue_ram
  import biriscv_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr0_en,
  input  logic [DEPTH_W-1:0] wr0_addr,
  input  payload_t           wr0_data,
  input  logic               wr1_en,
  input  logic [DEPTH_W-1:0] wr1_addr,
  input  payload_t           wr1_data,
  input  logic [DEPTH_W-1:0] rd0_addr,
  output payload_t           rd0_data,
  input  logic [DEPTH_W-1:0] rd1_addr,
  output payload_t           rd1_data
);

  payload_t mem [DEPTH];

  // Storage writes; the two write addresses never collide when both are enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0_en) mem[wr0_addr] <= wr0_data;
      if (wr1_en) mem[wr1_addr] <= wr1_data;
    end
  end

  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Dual-port in-order instruction queue between decode and issue. Absorbs
// issue stalls and empties in one cycle on a pipeline redirect.
// Handshake: a beat transfers on a cycle where valid and accept are both high
// at the rising edge; out1 transfers only together with out0 (age order),
// and in1 is written behind in0 when both transfer.
module biriscv_fetch_queue
  import biriscv_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,

  input  logic               in0_valid_i,
  input  logic [31:0]        in0_instr_i,
  input  logic [31:0]        in0_pc_i,
  input  logic               in0_fault_fetch_i,
  input  logic               in0_fault_page_i,
  input  logic [7:0]         in0_flags_i,
  output logic               in0_accept_o,

  input  logic               in1_valid_i,
  input  logic [31:0]        in1_instr_i,
  input  logic [31:0]        in1_pc_i,
  input  logic               in1_fault_fetch_i,
  input  logic               in1_fault_page_i,
  input  logic [7:0]         in1_flags_i,
  output logic               in1_accept_o,

  output logic               out0_valid_o,
  output logic [31:0]        out0_instr_o,
  output logic [31:0]        out0_pc_o,
  output logic               out0_fault_fetch_o,
  output logic               out0_fault_page_o,
  output logic [7:0]         out0_flags_o,
  input  logic               out0_accept_i,

  output logic               out1_valid_o,
  output logic [31:0]        out1_instr_o,
  output logic [31:0]        out1_pc_o,
  output logic               out1_fault_fetch_o,
  output logic               out1_fault_page_o,
  output logic [7:0]         out1_flags_o,
  input  logic               out1_accept_i,

  output logic [DEPTH_W:0]   level_o
);

  localparam logic [DEPTH_W:0] LIM_ONE = (DEPTH_W+1)'(DEPTH - 1);
  localparam logic [DEPTH_W:0] LIM_TWO = (DEPTH_W+1)'(DEPTH - 2);

  logic [DEPTH_W-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_W:0]   count;
  logic               push0, push1, pop0, pop1;
  logic [1:0]         n_push, n_pop;
  payload_t           rd0_data, rd1_data;

  // Space is judged on the start-of-cycle count; same-cycle pops do not free room
  assign in0_accept_o = (count <= LIM_ONE);
  assign in1_accept_o = in0_valid_i ? (count <= LIM_TWO) : (count <= LIM_ONE);

  assign push0 = in0_valid_i & in0_accept_o;
  assign push1 = in1_valid_i & in1_accept_o;

  assign out0_valid_o = (count >= (DEPTH_W+1)'(1));
  assign out1_valid_o = (count >= (DEPTH_W+1)'(2));

  assign pop0 = out0_valid_o & out0_accept_i;
  assign pop1 = pop0 & out1_valid_o & out1_accept_i;

  assign n_push = {1'b0, push0} + {1'b0, push1};
  assign n_pop  = {1'b0, pop0} + {1'b0, pop1};

  assign level_o = count;

  // Pointer and occupancy update; a redirect discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_W'(n_push);
      rd_ptr <= rd_ptr + DEPTH_W'(n_pop);
      count  <= count + (DEPTH_W+1)'(n_push) - (DEPTH_W+1)'(n_pop);
    end
  end

  // A lone in1 beat lands at wr_ptr, making it the oldest new entry
  biriscv_fetch_queue_ram #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (push0 & ~flush_i),
    .wr0_addr (wr_ptr),
    .wr0_data (pack_payload(in0_instr_i, in0_pc_i, in0_fault_fetch_i,
                            in0_fault_page_i, in0_flags_i)),
    .wr1_en   (push1 & ~flush_i),
    .wr1_addr (wr_ptr + DEPTH_W'(push0)),
    .wr1_data (pack_payload(in1_instr_i, in1_pc_i, in1_fault_fetch_i,
                            in1_fault_page_i, in1_flags_i)),
    .rd0_addr (rd_ptr),
    .rd0_data (rd0_data),
    .rd1_addr (rd_ptr + DEPTH_W'(1)),
    .rd1_data (rd1_data)
  );

  assign out0_instr_o       = rd0_data[INSTR_LSB +: 32];
  assign out0_pc_o          = rd0_data[PC_LSB +: 32];
  assign out0_fault_fetch_o = rd0_data[FAULT_FETCH_BIT];
  assign out0_fault_page_o  = rd0_data[FAULT_PAGE_BIT];
  assign out0_flags_o       = rd0_data[FLAGS_LSB +: 8];

  assign out1_instr_o       = rd1_data[INSTR_LSB +: 32];
  assign out1_pc_o          = rd1_data[PC_LSB +: 32];
  assign out1_fault_fetch_o = rd1_data[FAULT_FETCH_BIT];
  assign out1_fault_page_o  = rd1_data[FAULT_PAGE_BIT];
  assign out1_flags_o       = rd1_data[FLAGS_LSB +: 8];

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Self-checking bench for biriscv_fetch_queue: directed scenarios followed by
// a long random push/pop/flush mix, all compared against a queue model.
module tb_biriscv_fetch_queue;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        flush;
  logic        in0_valid, in1_valid, in0_accept, in1_accept;
  logic [73:0] in0_pl, in1_pl;
  logic        out0_valid, out1_valid, out0_accept, out1_accept;
  logic [31:0] out0_instr, out0_pc, out1_instr, out1_pc;
  logic        out0_ff, out0_fp, out1_ff, out1_fp;
  logic [7:0]  out0_flags, out1_flags;
  logic [DEPTH_W:0] level;

  biriscv_fetch_queue #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush),
    .in0_valid_i        (in0_valid),
    .in0_instr_i        (in0_pl[73:42]),
    .in0_pc_i           (in0_pl[41:10]),
    .in0_fault_fetch_i  (in0_pl[9]),
    .in0_fault_page_i   (in0_pl[8]),
    .in0_flags_i        (in0_pl[7:0]),
    .in0_accept_o       (in0_accept),
    .in1_valid_i        (in1_valid),
    .in1_instr_i        (in1_pl[73:42]),
    .in1_pc_i           (in1_pl[41:10]),
    .in1_fault_fetch_i  (in1_pl[9]),
    .in1_fault_page_i   (in1_pl[8]),
    .in1_flags_i        (in1_pl[7:0]),
    .in1_accept_o       (in1_accept),
    .out0_valid_o       (out0_valid),
    .out0_instr_o       (out0_instr),
    .out0_pc_o          (out0_pc),
    .out0_fault_fetch_o (out0_ff),
    .out0_fault_page_o  (out0_fp),
    .out0_flags_o       (out0_flags),
    .out0_accept_i      (out0_accept),
    .out1_valid_o       (out1_valid),
    .out1_instr_o       (out1_instr),
    .out1_pc_o          (out1_pc),
    .out1_fault_fetch_o (out1_ff),
    .out1_fault_page_o  (out1_fp),
    .out1_flags_o       (out1_flags),
    .out1_accept_i      (out1_accept),
    .level_o            (level)
  );

  // ---------------- scoreboard ----------------
  logic [73:0] exp_q[$];
  int asserts_cnt = 0;
  int fail_cnt    = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    asserts_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] mk(input logic [31:0] pc);
    logic [31:0] instr;
    logic [7:0]  flg;
    instr = $urandom();
    flg   = 8'($urandom_range(0, 255));
    return {instr, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), flg};
  endfunction

  // One clock: check every output against the model mid-cycle, then apply
  // the cycle's transfers to the model and advance past the rising edge.
  task automatic step();
    int   sz;
    logic acc0, acc1, p0, p1, q0, q1;
    @(negedge clk);
    sz   = exp_q.size();
    acc0 = (sz <= DEPTH - 1);
    acc1 = in0_valid ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1);
    chk("in0_accept", 74'(in0_accept), 74'(acc0));
    chk("in1_accept", 74'(in1_accept), 74'(acc1));
    chk("level", 74'(level), 74'(sz));
    chk("out0_valid", 74'(out0_valid), 74'(sz >= 1));
    chk("out1_valid", 74'(out1_valid), 74'(sz >= 2));
    if (sz >= 1) chk("out0_payload", {out0_instr, out0_pc, out0_ff, out0_fp, out0_flags}, exp_q[0]);
    if (sz >= 2) chk("out1_payload", {out1_instr, out1_pc, out1_ff, out1_fp, out1_flags}, exp_q[1]);
    q0 = (sz >= 1) && out0_accept;
    q1 = q0 && (sz >= 2) && out1_accept;
    p0 = in0_valid && acc0;
    p1 = in1_valid && acc1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (q0) void'(exp_q.pop_front());
      if (q1) void'(exp_q.pop_front());
      if (p0) exp_q.push_back(in0_pl);
      if (p1) exp_q.push_back(in1_pl);
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus with explicit PCs, then run it.
  task automatic drv(input logic v0, input logic v1, input logic a0, input logic a1,
                     input logic fl, input logic [31:0] pc0, input logic [31:0] pc1);
    in0_valid   = v0;
    in1_valid   = v1;
    out0_accept = a0;
    out1_accept = a1;
    flush       = fl;
    in0_pl      = mk(pc0);
    in1_pl      = mk(pc1);
    step();
  endtask

  task automatic drv_auto(input logic v0, input logic v1, input logic a0, input logic a1,
                          input logic fl);
    drv(v0, v1, a0, a1, fl, pc_ctr, pc_ctr + 32'd4);
    pc_ctr = pc_ctr + 32'd8;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    flush = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    out0_accept = 1'b0; out1_accept = 1'b0;
    in0_pl = '0; in1_pl = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 74'(level), 74'(0));
    chk("rst_out0_valid", 74'(out0_valid), 74'(0));
    chk("rst_out1_valid", 74'(out1_valid), 74'(0));
    chk("rst_in0_accept", 74'(in0_accept), 74'(1));
    chk("rst_in1_accept", 74'(in1_accept), 74'(1));
    chk("rst_out0_payload", {out0_instr, out0_pc, out0_ff, out0_fp, out0_flags}, 74'(0));
    chk("rst_out1_payload", {out1_instr, out1_pc, out1_ff, out1_fp, out1_flags}, 74'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Dual push, visible next cycle
    drv(1, 1, 0, 0, 0, 32'h8000_0000, 32'h8000_0004);
    chk("dual_out0_pc", 74'(out0_pc), 74'(32'h8000_0000));
    chk("dual_out1_pc", 74'(out1_pc), 74'(32'h8000_0004));
    chk("dual_valids", 74'({out0_valid, out1_valid}), 74'(2'b11));
    chk("dual_level", 74'(level), 74'(2));

    // Fill with issue stalled; count=7 with both valid takes only in0
    drv_auto(1, 1, 0, 0, 0);
    drv_auto(1, 1, 0, 0, 0);
    drv_auto(1, 0, 0, 0, 0);
    chk("near_full_level", 74'(level), 74'(7));
    drv_auto(1, 1, 0, 0, 0);
    chk("full_level", 74'(level), 74'(8));
    chk("full_accepts", 74'({in0_accept, in1_accept}), 74'(2'b00));

    // Full with a double pop: pushes refused, then accepted next cycle
    drv_auto(1, 1, 1, 1, 0);
    chk("full_pop_level", 74'(level), 74'(6));
    drv_auto(1, 1, 0, 0, 0);
    chk("refill_level", 74'(level), 74'(8));

    // Lone in1 beat into an empty queue
    drv_auto(0, 0, 0, 0, 1);
    chk("flush_level", 74'(level), 74'(0));
    drv(0, 1, 0, 0, 0, 32'h0, 32'h0000_0100);
    chk("lone_in1_out0_pc", 74'(out0_pc), 74'(32'h0000_0100));
    chk("lone_in1_out1_valid", 74'(out1_valid), 74'(0));

    // out1-only accept must not pop
    drv_auto(0, 0, 0, 1, 0);
    chk("out1_only_level", 74'(level), 74'(1));

    // Flush at count=5 together with a push and a pop
    drv_auto(0, 0, 0, 0, 1);
    drv_auto(1, 1, 0, 0, 0);
    drv_auto(1, 1, 0, 0, 0);
    drv_auto(1, 0, 0, 0, 0);
    chk("pre_flush_level", 74'(level), 74'(5));
    drv_auto(1, 1, 1, 0, 1);
    chk("post_flush_level", 74'(level), 74'(0));
    chk("post_flush_valids", 74'({out0_valid, out1_valid}), 74'(2'b00));
    drv(1, 0, 0, 0, 0, 32'h0000_0200, 32'h0);
    chk("post_flush_out0_pc", 74'(out0_pc), 74'(32'h0000_0200));

    // Reset mid-operation clears asynchronously; first push accepted after release
    drv_auto(1, 1, 0, 0, 0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", 74'(level), 74'(0));
    chk("async_rst_out0_valid", 74'(out0_valid), 74'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(1, 0, 0, 0, 0, 32'h0000_0300, 32'h0);
    chk("after_rst_out0_pc", 74'(out0_pc), 74'(32'h0000_0300));
    chk("after_rst_level", 74'(level), 74'(1));

    // Random mix
    for (int i = 0; i < 10000; i++) begin
      drv_auto($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 63) == 0);
    end

    // Drain and confirm empty
    for (int i = 0; i < 8; i++) drv_auto(0, 0, 1, 1, 0);
    chk("drain_level", 74'(level), 74'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
    $finish;
  end

endmodule
